logic_eval_arbiter: RTL and testbench
=====================================

# logic_eval_arbiter

Round-robin arbiter and sequencer that shares one registered instance of the team's bitwise logic evaluator, y = (a & b) | (c ^ d), among N_REQ requesters. Each requester presents an operand set {a, b, c, d} with a valid/ready handshake. The arbiter grants at most one requester per cycle and launches the evaluation. It returns the result with the winner's ID on a single valid/ready response port. It sits between the client blocks and the shared combinational datapath, and it adds the only state on that path.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- W, 4: operand and result width. All operations are bitwise.
- ID_W, 2: requester ID width. Must satisfy 2^ID_W >= N_REQ.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  bit i: requester i has an operand set pending.
- req_ready  out  N_REQ  bit i: requester i is accepted this cycle. At most one bit is high.
- req_a, req_b, req_c, req_d  in  N_REQ*W  packed operands; requester i occupies [i*W +: W].
- rsp_valid  out  1  result register holds a valid result.
- rsp_id  out  ID_W  index of the requester that owns rsp_y.
- rsp_y  out  W  result, (a & b) | (c ^ d).
- rsp_ready  in  1  downstream accepts the response this cycle.

## Operation
- Internal state:
  - rr_ptr (ID_W): index of the last granted requester.
  - One output register: rsp_valid, rsp_id, rsp_y.
- can_accept = !rsp_valid | rsp_ready.
- Winner selection:
  - Search req_valid starting at index rr_ptr+1 and wrap modulo N_REQ.
  - The first set bit wins.
- req_ready[winner] = can_accept. This is a combinational function of req_valid, rr_ptr, rsp_valid and rsp_ready. All other req_ready bits are 0.
- Acceptance of requester i occurs when req_valid[i] & req_ready[i]. On the next edge:
  - rsp_valid <= 1
  - rsp_id <= i
  - rsp_y <= (a_i & b_i) | (c_i ^ d_i)
  - rr_ptr <= i
- No acceptance and rsp_valid & rsp_ready: rsp_valid <= 0. rsp_id, rsp_y and rr_ptr hold.
- No acceptance and no drain: all state holds.
- Backpressure (rsp_valid & !rsp_ready):
  - rsp_valid, rsp_id and rsp_y are stable.
  - req_ready is all 0.
  - rr_ptr holds.
- Requester rule: once asserted, req_valid[i] and its operands stay stable until accepted. The arbiter does not check this rule.
- rr_ptr changes only on an acceptance. Idle cycles do not rotate priority.
- Fairness: a continuously requesting requester is accepted within N_REQ accepting cycles.

## Timing
- Reset values (asynchronous, while rst is high):
  - rsp_valid = 0, rsp_id = 0, rsp_y = 0
  - rr_ptr = N_REQ-1, so requester 0 has first priority after reset.
  - req_ready = 0 while rst is high.
- Latency: an acceptance in cycle t gives rsp_valid = 1 in cycle t+1.
- Throughput: 1 result per cycle while rsp_ready stays high.
- Simultaneous drain and accept in one cycle: the new result replaces the drained one. rsp_valid stays 1 and there is no bubble.
- Reset asserted mid-operation: any pending response is discarded immediately, with no handshake completion. The first acceptance after reset release can occur in the first cycle that rst is low.
- N_REQ not a power of two: rr_ptr+1 wraps from N_REQ-1 to 0. IDs >= N_REQ never appear.

## Test plan
(All scenarios use N_REQ = 4, W = 4.)
- Reset and single request:
  - Hold rst for 2 cycles → rsp_valid = 0, rsp_id = 0, rsp_y = 0, req_ready = 0000.
  - After release, drive req_valid = 0001 with a = C, b = A, c = 1, d = 2 → req_ready = 0001 in that cycle.
  - Next cycle: rsp_valid = 1, rsp_id = 0, rsp_y = B.
- Full contention: req_valid = 1111 held, new operands after each acceptance, rsp_ready = 1 → accepted IDs 0,1,2,3,0,1 on consecutive cycles. rsp_valid stays high with no bubbles.
- Backpressure:
  - With rsp_valid = 1 (id 2, y = 5), hold rsp_ready = 0 for 3 cycles while req_valid = 1111 → rsp_id = 2, rsp_y = 5 stable, req_ready = 0000.
  - In the cycle rsp_ready = 1: req_ready = 1000. Next cycle rsp_id = 3.
- Sparse fairness: req_valid = 1010 held, rsp_ready = 1 → acceptances alternate 1,3,1,3. An idle gap of 4 cycles with req_valid = 0000, then 1010 again → requester after the last winner is accepted first (1 if the last winner was 3).
- Drain with no new request: rsp_valid = 1, rsp_ready = 1, req_valid = 0000 → next cycle rsp_valid = 0, rsp_y unchanged, rr_ptr unchanged.
- Reset mid-operation: assert rst asynchronously between edges while rsp_valid = 1 and rsp_ready = 0 → rsp_valid drops to 0 immediately, without waiting for a clock edge. After release with req_valid = 0100 → requester 2 is accepted in the first cycle.

Source files
------------

// File: rtl/logic_eval_arbiter.sv
// logic_eval_arbiter
// Round-robin arbiter that shares one registered bitwise evaluator,
// y = (a & b) | (c ^ d), among N_REQ requesters.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [N_REQ]    per-requester operand set pending
//   req_ready  [N_REQ]    per-requester accept strobe (one-hot or zero)
//   req_a..d   [N_REQ*W]  packed operands, requester i at [i*W +: W]
//   rsp_valid  result register holds a valid result
//   rsp_id     [ID_W]     owner of rsp_y
//   rsp_y      [W]        evaluated result
//   rsp_ready  downstream accepts the response this cycle
module logic_eval_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_c,
    input  logic [N_REQ*W-1:0] req_d,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_y,
    input  logic               rsp_ready
);

    logic            rsp_valid_reg;
    logic [ID_W-1:0] rsp_id_reg;
    logic [W-1:0]    rsp_y_reg;
    logic [ID_W-1:0] rr_ptr_reg;

    logic            found;
    logic [ID_W-1:0] winner;
    logic            can_accept;
    logic            accept;
    logic [W-1:0]    y_sel;
    logic [W-1:0]    y_vec [N_REQ];

    // Evaluate every requester's operands in parallel; the winner's result
    // is picked afterwards so the datapath stays a simple mux.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_eval
            assign y_vec[gi] = (req_a[gi*W +: W] & req_b[gi*W +: W])
                             | (req_c[gi*W +: W] ^ req_d[gi*W +: W]);
        end
    endgenerate

    // Search starts just past the last winner and wraps modulo N_REQ,
    // so IDs >= N_REQ can never be produced even for non-power-of-two N_REQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign y_sel      = y_vec[winner];
    assign can_accept = !rsp_valid_reg || rsp_ready;
    // rst gates acceptance so no requester sees a handshake while in reset.
    assign accept     = found && can_accept && !rst;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (winner == ID_W'(gi));
        end
    endgenerate

    // A drain and a new acceptance in the same cycle simply overwrite the
    // register, giving back-to-back results with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_y_reg     <= '0;
            rr_ptr_reg    <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= winner;
            rsp_y_reg     <= y_sel;
            rr_ptr_reg    <= winner;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
module tb_logic_eval_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b, req_c, req_d;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_ready;

    logic_eval_arbiter #(.N_REQ(N), .W(W), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] y;
    } rsp_t;

    rsp_t       q[$];
    logic [3:0] op_a [N];
    logic [3:0] op_b [N];
    logic [3:0] op_c [N];
    logic [3:0] op_d [N];
    int         m_ptr;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check response register and req_ready
    // against the scoreboard, then advance to just after the next edge.
    task automatic cycle(input logic [3:0] v, input logic rr,
                         output logic acc, output logic [1:0] id);
        logic [3:0] exp_ready;
        rsp_t       e;
        int         j;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_c[i*W +: W] = op_c[i];
            req_d[i*W +: W] = op_d[i];
        end
        #1;
        if (q.size() > 0) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_y", rsp_y, q[0].y);
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
        end
        acc = 1'b0;
        id = 2'd0;
        exp_ready = 4'b0000;
        if (q.size() == 0 || rr) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (!acc && v[j]) begin
                    acc = 1'b1;
                    id = 2'(j);
                end
            end
        end
        if (acc) exp_ready[id] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        if (q.size() > 0 && rr) begin
            e = q.pop_front();
            $display("drain id=%0d y=%h", e.id, e.y);
        end
        if (acc) begin
            e.id = id;
            e.y  = (op_a[id] & op_b[id]) | (op_c[id] ^ op_d[id]);
            q.push_back(e);
            m_ptr = id;
            $display("accept id=%0d y=%h", e.id, e.y);
            op_a[id] = 4'($urandom);
            op_b[id] = 4'($urandom);
            op_c[id] = 4'($urandom);
            op_d[id] = 4'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       acc;
        logic [1:0] id;
        logic [1:0] last;
        logic [3:0] saved_y;

        for (int i = 0; i < N; i++) begin
            op_a[i] = 4'($urandom);
            op_b[i] = 4'($urandom);
            op_c[i] = 4'($urandom);
            op_d[i] = 4'($urandom);
        end
        m_ptr = N - 1;
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_d = '0;

        // Reset and single request
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", rsp_valid, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_y", rsp_y, 0);
        chk("reset_ready", req_ready, 4'b0000);
        rst = 1'b0;
        op_a[0] = 4'hC; op_b[0] = 4'hA; op_c[0] = 4'h1; op_d[0] = 4'h2;
        cycle(4'b0001, 1'b1, acc, id);
        chk("first_acc", {acc, id}, {1'b1, 2'd0});
        chk("first_y", rsp_y, 4'hB);

        // Full contention: round-robin continues from requester 0
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1, acc, id);
            chk("contention_id", {acc, id}, {1'b1, 2'((k + 1) % N)});
        end
        op_a[2] = 4'h5; op_b[2] = 4'hF; op_c[2] = 4'h0; op_d[2] = 4'h0;
        cycle(4'b1111, 1'b1, acc, id);
        chk("contention_id2", {acc, id}, {1'b1, 2'd2});

        // Backpressure with id 2 / y 5 held
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 1'b0, acc, id);
            chk("bp_id", rsp_id, 2);
            chk("bp_y", rsp_y, 4'h5);
        end
        cycle(4'b1111, 1'b1, acc, id);
        chk("bp_release", {acc, id}, {1'b1, 2'd3});

        // Sparse fairness
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1010, 1'b1, acc, id);
            chk("sparse_id", {acc, id}, {1'b1, (k % 2 == 0) ? 2'd1 : 2'd3});
            last = id;
        end
        repeat (4) cycle(4'b0000, 1'b1, acc, id);
        cycle(4'b1010, 1'b1, acc, id);
        chk("after_gap", {acc, id}, {1'b1, (last == 2'd3) ? 2'd1 : 2'd3});

        // Drain with no new request
        saved_y = rsp_y;
        cycle(4'b0000, 1'b1, acc, id);
        chk("drain_valid", rsp_valid, 0);
        chk("drain_y", rsp_y, saved_y);
        cycle(4'b1010, 1'b1, acc, id);
        chk("ptr_held", {acc, id}, {1'b1, 2'd3});

        // Reset mid-operation while backpressured
        cycle(4'b0000, 1'b0, acc, id);
        req_valid = 4'b0100;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_ready", req_ready, 4'b0000);
        q.delete();
        m_ptr = N - 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(4'b0100, 1'b1, acc, id);
        chk("post_rst_acc", {acc, id}, {1'b1, 2'd2});
        cycle(4'b0000, 1'b1, acc, id);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
